i2c_bus_master: RTL and testbench

- Single-transaction I2C bus master that generates SCL/SDA to drive the I2C register-slave's SCL_in/SDA_in pins.
- Used as the on-chip/bench stimulus stage and as the host-side controller in integrated builds.
- Performs one register write (addr+W, reg, data) or one register read (addr+W, reg, repeated START, addr+R, data, master NACK) per request.
- Open-drain is modelled as active-low drive outputs: 1 = released, 0 = pulled low.

---
 rtl/i2c_master_pkg.sv | 35 +++
 rtl/i2c_tick_gen.sv | 31 +++
 rtl/i2c_bus_master.sv | 205 ++++++++++++++++++++
 tb/tb_i2c_bus_master.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// Shared types for the single-transaction I2C bus master.
package i2c_master_pkg;

  localparam int BITS_PER_BYTE = 8;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR_W,
    ACK_A,
    REG,
    ACK_R,
    WDATA,
    ACK_D,
    RSTART,
    ADDR_R,
    ACK_B,
    RDATA,
    MNACK,
    STOP
  } master_state_t;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  // States that move eight bits and advance the bit counter
  function automatic logic is_byte_state(input master_state_t s);
    return s inside {ADDR_W, REG, WDATA, ADDR_R, RDATA};
  endfunction

  // States where the slave is expected to pull SDA low
  function automatic logic is_ack_state(input master_state_t s);
    return s inside {ACK_A, ACK_R, ACK_D, ACK_B};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-bit phase divider: counts 0..CLK_DIV-1 while enabled and pulses
// tick on the terminal count. hold freezes the count (slave clock stretch).
module i2c_tick_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic hold,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Divider count; cleared whenever the master is idle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (!hold) begin
      cnt <= (cnt == TC) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && !hold && (cnt == TC);

endmodule

// File: rtl/i2c_bus_master.sv
// Single-transaction I2C master: one register write or one register read
// (with repeated START and master NACK) per start_req. SCL_out/SDA_out are
// open-drain enables: 1 = released, 0 = pulled low.
// Optional build macro I2C_CLOCK_STRETCH_EN: divider freezes in P2 while
// SCL_in is low so a slave can stretch the clock.
//
// state  | meaning
// IDLE   | bus released, waiting for start_req
// START  | START condition
// ADDR_W | shift out {dev_addr, 0}
// ACK_A  | slave ACK of write address
// REG    | shift out register select byte
// ACK_R  | slave ACK of register byte
// WDATA  | shift out write data byte
// ACK_D  | slave ACK of write data
// RSTART | repeated START before the read address
// ADDR_R | shift out {dev_addr, 1}
// ACK_B  | slave ACK of read address
// RDATA  | shift in read byte from P3 samples
// MNACK  | master NACK, SDA released
// STOP   | STOP condition, then done
module i2c_bus_master
  import i2c_master_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start_req,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       SDA_in,
  input  logic       SCL_in,
  output logic       SCL_out,
  output logic       SDA_out,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata
);

  master_state_t state_q, state_d;
  phase_t        phase_q;
  logic [2:0]    bit_cnt_q;
  logic          rw_q;
  logic [6:0]    dev_q;
  logic [7:0]    reg_q;
  logic [7:0]    wd_q;
  logic [7:0]    rx_q;
  logic          sda_smp_q;
  logic          p_first_q;

  logic          tick;
  logic          hold;
  logic          accept;
  logic          bit_end;
  logic          last_bit;
  logic          sample_now;
  logic [7:0]    tx_byte;
  logic          scl_hi;

  assign accept     = (state_q == IDLE) && start_req;
  assign bit_end    = tick && (phase_q == P3);
  assign last_bit   = (bit_cnt_q == 3'(BITS_PER_BYTE - 1));
  // First cycle of P3 is the cycle right after the tick that ended P2
  assign sample_now = busy && p_first_q && (phase_q == P3);

`ifdef I2C_CLOCK_STRETCH_EN
  assign hold = busy && (phase_q == P2) && !SCL_in;
`else
  logic unused_scl_in;
  assign unused_scl_in = SCL_in;
  assign hold          = 1'b0;
`endif

  i2c_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick (
    .clock(clock),
    .reset(reset),
    .en   (busy),
    .hold (hold),
    .tick (tick)
  );

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: everything but accept advances only at the end of a bit-time
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (accept) state_d = START;
      START:  if (bit_end) state_d = ADDR_W;
      ADDR_W: if (bit_end && last_bit) state_d = ACK_A;
      ACK_A:  if (bit_end) state_d = sda_smp_q ? STOP : REG;
      REG:    if (bit_end && last_bit) state_d = ACK_R;
      ACK_R:  if (bit_end) state_d = sda_smp_q ? STOP : (rw_q ? RSTART : WDATA);
      WDATA:  if (bit_end && last_bit) state_d = ACK_D;
      ACK_D:  if (bit_end) state_d = STOP;
      RSTART: if (bit_end) state_d = ADDR_R;
      ADDR_R: if (bit_end && last_bit) state_d = ACK_B;
      ACK_B:  if (bit_end) state_d = sda_smp_q ? STOP : RDATA;
      RDATA:  if (bit_end && last_bit) state_d = MNACK;
      MNACK:  if (bit_end) state_d = STOP;
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, phase/bit counters, SDA sampling and completion flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q   <= P0;
      bit_cnt_q <= '0;
      rw_q      <= 1'b0;
      dev_q     <= '0;
      reg_q     <= '0;
      wd_q      <= '0;
      rx_q      <= '0;
      sda_smp_q <= 1'b1;
      p_first_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack      <= 1'b0;
      rdata     <= '0;
    end else begin
      done      <= 1'b0;
      p_first_q <= tick;
      if (accept) begin
        rw_q      <= rw;
        dev_q     <= dev_addr;
        reg_q     <= reg_addr;
        wd_q      <= wdata;
        busy      <= 1'b1;
        nack      <= 1'b0;
        phase_q   <= P0;
        bit_cnt_q <= '0;
      end else if (busy) begin
        if (tick) phase_q <= phase_t'(phase_q + 2'd1);
        if (sample_now) sda_smp_q <= SDA_in;
        if (sample_now && state_q == RDATA) rx_q <= {rx_q[6:0], SDA_in};
        if (bit_end) begin
          if (is_byte_state(state_q)) bit_cnt_q <= bit_cnt_q + 3'd1;
          else                        bit_cnt_q <= '0;
          if (is_ack_state(state_q) && sda_smp_q) nack <= 1'b1;
          if (state_q == STOP) begin
            done <= 1'b1;
            busy <= 1'b0;
            if (rw_q && !nack) rdata <= rx_q;
          end
        end
      end
    end
  end

  // Bus drive decode from state and phase; data bits are held for the whole bit
  always_comb begin
    scl_hi  = (phase_q == P2) || (phase_q == P3);
    tx_byte = 8'h00;
    SCL_out = 1'b1;
    SDA_out = 1'b1;
    case (state_q)
      ADDR_W: tx_byte = {dev_q, 1'b0};
      REG:    tx_byte = reg_q;
      WDATA:  tx_byte = wd_q;
      ADDR_R: tx_byte = {dev_q, 1'b1};
      default: tx_byte = 8'h00;
    endcase
    case (state_q)
      IDLE: begin
        SCL_out = 1'b1;
        SDA_out = 1'b1;
      end
      START: begin
        SCL_out = 1'b1;
        SDA_out = (phase_q == P0) || (phase_q == P1);
      end
      // SCL stays low through P0 so the slave sees its ACK clock end and
      // lets go of SDA before SCL rises for the repeated START.
      RSTART: begin
        SCL_out = (phase_q != P0);
        SDA_out = (phase_q == P0) || (phase_q == P1);
      end
      STOP: begin
        SCL_out = scl_hi;
        SDA_out = (phase_q == P3);
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        SCL_out = scl_hi;
        SDA_out = tx_byte[3'd7 - bit_cnt_q];
      end
      default: begin
        SCL_out = scl_hi;
        SDA_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_bus_master.sv
// Bench for i2c_bus_master with a timed register-slave model on the bus.
module tb_i2c_bus_master;

  localparam int CLK_DIV = 8;
  localparam int T = 4 * CLK_DIV;
  localparam logic [6:0] SLV = 7'h2A;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start_req = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = '0;
  logic [7:0] reg_addr = '0;
  logic [7:0] wdata = '0;
  logic       SDA_in, SCL_in, SCL_out, SDA_out, busy, done, nack;
  logic [7:0] rdata;
  logic       slave_sda = 1'b1;
  logic       slave_scl = 1'b1;
  logic [7:0] sreg [256];
  int         total = 0;
  int         bad = 0;

  assign SDA_in = SDA_out & slave_sda;
  assign SCL_in = SCL_out & slave_scl;

  i2c_bus_master #(.CLK_DIV(CLK_DIV)) dut (
    .clock(clock), .reset(reset), .start_req(start_req), .rw(rw),
    .dev_addr(dev_addr), .reg_addr(reg_addr), .wdata(wdata),
    .SDA_in(SDA_in), .SCL_in(SCL_in), .SCL_out(SCL_out), .SDA_out(SDA_out),
    .busy(busy), .done(done), .nack(nack), .rdata(rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       r;
    logic [6:0] d;
    logic [7:0] ra;
    logic [7:0] w;
    logic       pre;
    logic [7:0] pre_v;
    int         exp_cyc;
    logic       exp_nack;
    logic [7:0] exp_rdata;
    logic [7:0] exp_sreg;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Starts one request and plays the slave side bit by bit from the expected
  // timing. stop_bit is the index of the STOP bit-time; abort_c asserts reset
  // at that cycle; stretch_bit holds SCL low 100 cycles in that bit's P2.
  task automatic run_txn(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] w, input int stop_bit, input bit hold_req,
                         input int abort_c, input int stretch_bit,
                         output int cycles, output int frame_err, output int mnack_err);
    int c, m, b, pos, ph, extra, left;
    logic [7:0] a1, rb, db, a2, ptr, tmp;
    logic addressed, rd_ok, e_scl;
    c = 0; extra = 0; left = 0; cycles = -1; frame_err = 0; mnack_err = 0;
    a1 = '0; rb = '0; db = '0; a2 = '0; ptr = '0; addressed = 0; rd_ok = 0;
    @(negedge clock);
    rw = r; dev_addr = d; reg_addr = ra; wdata = w; start_req = 1'b1;
    @(posedge clock);
    #1;
    if (!hold_req) start_req = 1'b0;
    while (c < stop_bit * T + T + 300) begin
      @(negedge clock);
      c++;
      if (done) begin
        cycles = c - 1;
        break;
      end
      if (c == abort_c) begin
        reset = 1'b0;
        #1;
        chk("abort_scl", 32'(SCL_out), 32'd1);
        chk("abort_sda", 32'(SDA_out), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        break;
      end
      if (left > 0) begin
        left--;
        extra++;
        if (left == 0) slave_scl = 1'b1;
        continue;
      end
      m = c - 1 - extra;
      b = m / T;
      pos = m % T;
      ph = pos / CLK_DIV;
      if (b == 9) addressed = (a1 == {SLV, 1'b0});
      if (b == 18) ptr = rb;
      slave_sda = 1'b1;
      if ((b == 9 || b == 18) && addressed) slave_sda = 1'b0;
      if (!r && b == 27 && addressed) begin
        slave_sda = 1'b0;
        if (pos == 0) sreg[ptr] = db;
      end
      if (r && b == 28 && addressed && a2 == {SLV, 1'b1}) begin
        rd_ok = 1'b1;
        slave_sda = 1'b0;
      end
      if (r && b >= 29 && b <= 36 && rd_ok) begin
        tmp = sreg[ptr];
        slave_sda = tmp[3'(36 - b)];
      end
      if (pos == 2 * CLK_DIV) begin
        if (b >= 1 && b <= 8)                a1 = {a1[6:0], SDA_in};
        else if (b >= 10 && b <= 17)         rb = {rb[6:0], SDA_in};
        else if (!r && b >= 19 && b <= 26)   db = {db[6:0], SDA_in};
        else if (r && b >= 20 && b <= 27)    a2 = {a2[6:0], SDA_in};
        if (b == stretch_bit) begin
          slave_scl = 1'b0;
          left = 100;
        end
      end
      if (b == 0)                                   e_scl = 1'b1;
      else if (r && stop_bit == 38 && b == 19)      e_scl = (ph != 0);
      else                                          e_scl = (ph >= 2);
      if (SCL_out !== e_scl) frame_err++;
      if (b == 0 || (r && stop_bit == 38 && b == 19)) begin
        if (SDA_out !== (ph < 2)) frame_err++;
      end
      if (b == stop_bit && SDA_out !== (ph == 3)) frame_err++;
      if (r && b == 37 && SDA_out !== 1'b1) mnack_err++;
    end
    slave_sda = 1'b1;
  endtask

  initial begin
    int cyc, ferr, merr, n;
    for (int i = 0; i < 256; i++) sreg[i] = 8'h00;
    vecs[0] = '{1'b0, SLV,   8'h03, 8'h5A, 1'b0, 8'h00, 29 * T, 1'b0, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, SLV,   8'h03, 8'h00, 1'b1, 8'hC4, 39 * T, 1'b0, 8'hC4, 8'hC4};
    vecs[2] = '{1'b0, 7'h51, 8'h03, 8'hFF, 1'b0, 8'h00, 11 * T, 1'b1, 8'hC4, 8'hC4};
    vecs[3] = '{1'b1, 7'h51, 8'h03, 8'h00, 1'b0, 8'h00, 11 * T, 1'b1, 8'hC4, 8'hC4};
    vecs[4] = '{1'b0, SLV,   8'h81, 8'hA5, 1'b0, 8'h00, 29 * T, 1'b0, 8'hC4, 8'hA5};
    vecs[5] = '{1'b1, SLV,   8'h81, 8'h00, 1'b0, 8'h00, 39 * T, 1'b0, 8'hA5, 8'hA5};

    // reset values
    repeat (3) @(negedge clock);
    chk("rst_scl", 32'(SCL_out), 32'd1);
    chk("rst_sda", 32'(SDA_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_nack", 32'(nack), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;
    @(negedge clock);

    // table of write / read / wrong-address transactions
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre) sreg[vecs[i].ra] = vecs[i].pre_v;
      run_txn(vecs[i].r, vecs[i].d, vecs[i].ra, vecs[i].w, vecs[i].exp_cyc / T - 1,
              1'b0, 0, -1, cyc, ferr, merr);
      chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].exp_cyc));
      chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_nack", i), 32'(nack), 32'(vecs[i].exp_nack));
      chk($sformatf("v%0d_rdata", i), 32'(rdata), 32'(vecs[i].exp_rdata));
      chk($sformatf("v%0d_frame_err", i), 32'(ferr), 32'd0);
      chk($sformatf("v%0d_mnack_err", i), 32'(merr), 32'd0);
      chk($sformatf("v%0d_slave_reg", i), 32'(sreg[vecs[i].ra]), 32'(vecs[i].exp_sreg));
      @(negedge clock);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start_req held for a whole write: one transaction, next accept after done
    run_txn(1'b0, SLV, 8'h10, 8'h77, 28, 1'b1, 0, -1, cyc, ferr, merr);
    chk("hold_cycles", 32'(cyc), 32'(29 * T));
    chk("hold_slave_reg", 32'(sreg[8'h10]), 32'h77);
    chk("hold_busy_at_done", 32'(busy), 32'd0);
    @(negedge clock);
    chk("hold_reaccept", 32'(busy), 32'd1);
    start_req = 1'b0;
    n = 0;
    while (n < 11 * T + 200) begin
      @(negedge clock);
      n++;
      if (done) break;
    end
    chk("hold_second_cycles", 32'(n), 32'(11 * T));
    chk("hold_second_nack", 32'(nack), 32'd1);
    @(negedge clock);

    // reset during WDATA (bit 19, P1: SCL low, SDA driving a 0)
    run_txn(1'b0, SLV, 8'h20, 8'h5A, 28, 1'b0, 19 * T + CLK_DIV + 1, -1, cyc, ferr, merr);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_nack", 32'(nack), 32'd0);
    chk("abort_rdata", 32'(rdata), 32'd0);
    run_txn(1'b0, SLV, 8'h20, 8'h3C, 28, 1'b0, 0, -1, cyc, ferr, merr);
    chk("after_abort_cycles", 32'(cyc), 32'(29 * T));
    chk("after_abort_nack", 32'(nack), 32'd0);
    chk("after_abort_frame", 32'(ferr), 32'd0);
    chk("after_abort_slave_reg", 32'(sreg[8'h20]), 32'h3C);
    @(negedge clock);

`ifdef I2C_CLOCK_STRETCH_EN
    // slave holds SCL low 100 cycles in P2 of a REG bit
    run_txn(1'b0, SLV, 8'h04, 8'h99, 28, 1'b0, 0, 12, cyc, ferr, merr);
    chk("stretch_cycles", 32'(cyc), 32'(29 * T + 100));
    chk("stretch_nack", 32'(nack), 32'd0);
    chk("stretch_frame", 32'(ferr), 32'd0);
    chk("stretch_slave_reg", 32'(sreg[8'h04]), 32'h99);
    @(negedge clock);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
